// File: rtl/tour_pkg.sv
// Shared types and constants for the Knight tour command sequencer.
package tour_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_SNT,
    ST_WAIT_RESP,
    ST_DONE
  } seq_state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_NACK    = 2'd1,
    ERR_TIMEOUT = 2'd2,
    ERR_ABORT   = 2'd3
  } err_code_t;

  localparam logic [7:0]  POS_ACK         = 8'hA5;
  localparam logic [15:0] CAL_GYRO        = 16'h2000;
  localparam logic [3:0]  OP_MOVE         = 4'h4;
  localparam logic [3:0]  OP_MOVE_FANFARE = 4'h5;

  function automatic logic [3:0] cmd_opcode(input logic [15:0] c);
    return c[15:12];
  endfunction

endpackage

// File: rtl/tour_sequencer_cmd_fifo.sv
// Command FIFO: wrap-bit pointers, combinational head for the sequencer's registered cmd.
module cmd_fifo #(
  parameter int DEPTH = 32,
  parameter int W     = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  // Full when the wrap bits differ and the index bits match.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign count = wr_ptr - rd_ptr;
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/tour_sequencer.sv
// Plays buffered Knight commands to RemoteComm one at a time, checking each
// response for the positive acknowledge with per-attempt timeout and retries.
module tour_sequencer
  import tour_pkg::*;
#(
  parameter int               DEPTH     = 32,
  parameter int               TMO_W     = 24,
  parameter logic [TMO_W-1:0] TIMEOUT   = 24'hFFFFFF,
  parameter int               MAX_RETRY = 2,
  parameter logic [7:0]       ACK_VAL   = POS_ACK
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ld_vld,
  input  logic [15:0]            ld_cmd,
  output logic                   ld_rdy,
  input  logic                   start,
  input  logic                   abort,
  output logic [15:0]            cmd,
  output logic                   snd_cmd,
  input  logic                   cmd_snt,
  input  logic                   resp_rdy,
  input  logic [7:0]             resp,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [1:0]             err_code,
  output logic [$clog2(DEPTH):0] cmds_done
);

  localparam int               CW       = $clog2(DEPTH) + 1;
  localparam int               RTW      = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RTW-1:0]   MAX_R    = RTW'(MAX_RETRY);
  localparam logic [TMO_W-1:0] TMO_LAST = TIMEOUT - TMO_W'(1);

  seq_state_t       state;
  err_code_t        err_code_q;
  logic [TMO_W-1:0] timer;
  logic [RTW-1:0]   retry_cnt;
  logic             reload;

  logic [15:0]      fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic             push_en;
  logic             pop_en;
  logic             ack_hit;
  logic             last_cmd;

  assign ld_rdy   = !fifo_full;
  assign push_en  = ld_vld && !fifo_full;
  assign ack_hit  = (state == ST_WAIT_RESP) && resp_rdy && (resp == ACK_VAL);
  assign pop_en   = ack_hit && !abort;
  // A push landing in the same cycle as the final pop keeps the run going.
  assign last_cmd = (fifo_count == CW'(1)) && !push_en;
  assign busy     = (state != ST_IDLE);
  assign err_code = err_code_q;

  cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (16)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_en),
    .pop   (pop_en),
    .flush (abort),
    .din   (ld_cmd),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      err_code_q <= ERR_NONE;
      timer      <= '0;
      retry_cnt  <= '0;
      reload     <= 1'b0;
      cmd        <= '0;
      snd_cmd    <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      cmds_done  <= '0;
    end else begin
      snd_cmd <= 1'b0;
      done    <= 1'b0;
      if (abort && state != ST_IDLE) begin
        state      <= ST_IDLE;
        reload     <= 1'b0;
        err        <= 1'b1;
        err_code_q <= ERR_ABORT;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start && !abort) begin
              err        <= 1'b0;
              err_code_q <= ERR_NONE;
              cmds_done  <= '0;
              retry_cnt  <= '0;
              if (fifo_empty) begin
                state <= ST_DONE;
              end else begin
                state   <= ST_SEND;
                cmd     <= fifo_head;
                snd_cmd <= 1'b1;
              end
            end
          end
          ST_SEND: begin
            // After an ACK the popped head settles for one cycle before the strobe.
            if (reload) begin
              reload  <= 1'b0;
              cmd     <= fifo_head;
              snd_cmd <= 1'b1;
            end else begin
              timer <= '0;
              state <= ST_WAIT_SNT;
            end
          end
          ST_WAIT_SNT, ST_WAIT_RESP: begin
            if (state == ST_WAIT_RESP && resp_rdy) begin
              if (resp == ACK_VAL) begin
                cmds_done <= cmds_done + CW'(1);
                retry_cnt <= '0;
                if (last_cmd) begin
                  state <= ST_DONE;
                end else begin
                  state  <= ST_SEND;
                  reload <= 1'b1;
                end
              end else begin
                err        <= 1'b1;
                err_code_q <= ERR_NACK;
                state      <= ST_IDLE;
              end
            end else if (timer == TMO_LAST) begin
              if (retry_cnt < MAX_R) begin
                retry_cnt <= retry_cnt + RTW'(1);
                state     <= ST_SEND;
                cmd       <= fifo_head;
                snd_cmd   <= 1'b1;
              end else begin
                err        <= 1'b1;
                err_code_q <= ERR_TIMEOUT;
                state      <= ST_IDLE;
              end
            end else begin
              timer <= timer + TMO_W'(1);
              if (state == ST_WAIT_SNT && cmd_snt) begin
                state <= ST_WAIT_RESP;
              end
            end
          end
          ST_DONE: begin
            done  <= 1'b1;
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tour_sequencer.sv
// Scoreboard bench for tour_sequencer with a stub RemoteComm responder.
module tb_tour_sequencer;
  import tour_pkg::*;

  localparam int DEPTH    = 4;
  localparam int CW       = $clog2(DEPTH) + 1;
  localparam int RESP_DLY = 20;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ld_vld = 1'b0;
  logic [15:0]   ld_cmd = '0;
  logic          ld_rdy;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [15:0]   cmd;
  logic          snd_cmd;
  logic          cmd_snt = 1'b0;
  logic          resp_rdy = 1'b0;
  logic [7:0]    resp = '0;
  logic          busy;
  logic          done;
  logic          err;
  logic [1:0]    err_code;
  logic [CW-1:0] cmds_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int start_cyc = 0;
  int model_cnt = 0;
  bit stub_en = 1'b1;

  logic [15:0] exp_q[$];
  logic [15:0] obs_cmd[$];
  int          obs_cyc[$];
  int          resp_cyc[$];
  int          plan[$];

  tour_sequencer #(
    .DEPTH     (DEPTH),
    .TMO_W     (24),
    .TIMEOUT   (24'd50),
    .MAX_RETRY (2),
    .ACK_VAL   (8'hA5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ld_vld    (ld_vld),
    .ld_cmd    (ld_cmd),
    .ld_rdy    (ld_rdy),
    .start     (start),
    .abort     (abort),
    .cmd       (cmd),
    .snd_cmd   (snd_cmd),
    .cmd_snt   (cmd_snt),
    .resp_rdy  (resp_rdy),
    .resp      (resp),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .err_code  (err_code),
    .cmds_done (cmds_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: records every strobe and done pulse.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (snd_cmd) begin
        obs_cmd.push_back(cmd);
        obs_cyc.push_back(cyc);
        $display("[%0d] snd_cmd cmd=%h", cyc, cmd);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // Stub RemoteComm: cmd_snt 3 cycles after the strobe, then a planned response (-1 = silent).
  initial forever begin
    @(negedge clk);
    if (stub_en && rst_n && snd_cmd) begin
      int r;
      r = (plan.size() > 0) ? plan.pop_front() : 32'hA5;
      repeat (3) @(negedge clk);
      cmd_snt = 1'b1;
      @(negedge clk);
      cmd_snt = 1'b0;
      if (r >= 0) begin
        repeat (RESP_DLY) @(negedge clk);
        resp = r[7:0];
        resp_rdy = 1'b1;
        resp_cyc.push_back(cyc);
        @(negedge clk);
        resp_rdy = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_obs();
    obs_cmd.delete();
    obs_cyc.delete();
    resp_cyc.delete();
    done_cnt = 0;
  endtask

  task automatic load(input logic [15:0] w);
    checks++;
    if (ld_rdy !== 1'(model_cnt < DEPTH)) begin
      errors++;
      $display("FAIL ld_rdy before push %h: got %b expected %b", w, ld_rdy, model_cnt < DEPTH);
    end
    ld_cmd = w;
    ld_vld = 1'b1;
    if (model_cnt < DEPTH) begin
      exp_q.push_back(w);
      model_cnt++;
    end
    @(negedge clk);
    ld_vld = 1'b0;
    $display("[%0d] load %h ld_rdy=%b", cyc, w, ld_rdy);
  endtask

  task automatic pulse_start();
    start_cyc = cyc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    checks += 8;
    if (cmd !== 16'h0)     begin errors++; $display("FAIL reset cmd: got %h expected 0", cmd); end
    if (snd_cmd !== 1'b0)  begin errors++; $display("FAIL reset snd_cmd: got %b expected 0", snd_cmd); end
    if (busy !== 1'b0)     begin errors++; $display("FAIL reset busy: got %b expected 0", busy); end
    if (done !== 1'b0)     begin errors++; $display("FAIL reset done: got %b expected 0", done); end
    if (err !== 1'b0)      begin errors++; $display("FAIL reset err: got %b expected 0", err); end
    if (err_code !== 2'd0) begin errors++; $display("FAIL reset err_code: got %0d expected 0", err_code); end
    if (cmds_done !== '0)  begin errors++; $display("FAIL reset cmds_done: got %0d expected 0", cmds_done); end
    if (ld_rdy !== 1'b1)   begin errors++; $display("FAIL reset ld_rdy: got %b expected 1", ld_rdy); end
    $display("[%0d] reset state checked", cyc);
  endtask

  task automatic test_basic_ack();
    bit ok;
    int c0, c1, a0;
    logic [15:0] got, want;
    clear_obs();
    load(CAL_GYRO);
    load(16'h4BF1);
    load(16'h57F2);
    pulse_start();
    wait_idle(1000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic run: still busy after budget, expected idle"); end
    c0 = (obs_cyc.size() > 0) ? obs_cyc[0] : -1;
    c1 = (obs_cyc.size() > 1) ? obs_cyc[1] : -1;
    a0 = (resp_cyc.size() > 0) ? resp_cyc[0] : -100;
    checks += 2;
    if (c0 != start_cyc + 1) begin errors++; $display("FAIL start_to_snd: got cycle %0d expected %0d", c0, start_cyc + 1); end
    if (c1 != a0 + 2) begin errors++; $display("FAIL ack_to_snd: got cycle %0d expected %0d", c1, a0 + 2); end
    checks++;
    if (obs_cmd.size() != 3) begin errors++; $display("FAIL basic snd count: got %0d expected 3", obs_cmd.size()); end
    for (int i = 0; i < 3; i++) begin
      want = exp_q.pop_front();
      got = (obs_cmd.size() > 0) ? obs_cmd.pop_front() : 16'hxxxx;
      checks++;
      if (got !== want) begin errors++; $display("FAIL basic cmd%0d: got %h expected %h", i, got, want); end
    end
    model_cnt -= 3;
    checks += 3;
    if (done_cnt != 1) begin errors++; $display("FAIL basic done pulses: got %0d expected 1", done_cnt); end
    if (cmds_done !== CW'(3)) begin errors++; $display("FAIL basic cmds_done: got %0d expected 3", cmds_done); end
    if (err !== 1'b0) begin errors++; $display("FAIL basic err: got %b expected 0", err); end
    $display("[%0d] basic ack run complete cmds_done=%0d", cyc, cmds_done);
  endtask

  task automatic test_nack();
    bit ok;
    logic [15:0] got, want;
    clear_obs();
    load(16'h4101);
    load(16'h4202);
    load(16'h5303);
    plan.push_back(32'hA5);
    plan.push_back(32'h5A);
    pulse_start();
    wait_idle(1000, ok);
    checks += 6;
    if (!ok) begin errors++; $display("FAIL nack run: still busy after budget, expected idle"); end
    if (err !== 1'b1) begin errors++; $display("FAIL nack err: got %b expected 1", err); end
    if (err_code !== ERR_NACK) begin errors++; $display("FAIL nack err_code: got %0d expected 1", err_code); end
    if (cmds_done !== CW'(1)) begin errors++; $display("FAIL nack cmds_done: got %0d expected 1", cmds_done); end
    if (busy !== 1'b0) begin errors++; $display("FAIL nack busy: got %b expected 0", busy); end
    if (done_cnt != 0) begin errors++; $display("FAIL nack done pulses: got %0d expected 0", done_cnt); end
    want = exp_q.pop_front();
    got = (obs_cmd.size() > 0) ? obs_cmd.pop_front() : 16'hxxxx;
    checks++;
    if (got !== want) begin errors++; $display("FAIL nack cmd0: got %h expected %h", got, want); end
    model_cnt -= 1;
    want = exp_q[0];
    got = (obs_cmd.size() > 0) ? obs_cmd.pop_front() : 16'hxxxx;
    checks++;
    if (got !== want) begin errors++; $display("FAIL nack cmd1: got %h expected %h", got, want); end
    $display("[%0d] nack seen err_code=%0d cmds_done=%0d", cyc, err_code, cmds_done);
    // Replay: the two unacknowledged entries must still be queued, head first.
    clear_obs();
    pulse_start();
    wait_idle(1000, ok);
    checks += 4;
    if (!ok) begin errors++; $display("FAIL nack replay: still busy after budget, expected idle"); end
    if (obs_cmd.size() != 2) begin errors++; $display("FAIL nack replay count: got %0d expected 2", obs_cmd.size()); end
    if (cmds_done !== CW'(2)) begin errors++; $display("FAIL nack replay cmds_done: got %0d expected 2", cmds_done); end
    if (err !== 1'b0) begin errors++; $display("FAIL nack replay err: got %b expected 0", err); end
    for (int i = 0; i < 2; i++) begin
      want = exp_q.pop_front();
      got = (obs_cmd.size() > 0) ? obs_cmd.pop_front() : 16'hxxxx;
      checks++;
      if (got !== want) begin errors++; $display("FAIL nack replay cmd%0d: got %h expected %h", i, got, want); end
    end
    model_cnt -= 2;
    $display("[%0d] nack replay complete", cyc);
  endtask

  task automatic test_timeout();
    bit ok;
    int t0;
    logic [15:0] got, want;
    clear_obs();
    load(16'h4C11);
    repeat (3) plan.push_back(-1);
    pulse_start();
    wait_idle(600, ok);
    checks += 5;
    if (!ok) begin errors++; $display("FAIL timeout run: still busy after budget, expected idle"); end
    if (obs_cmd.size() != 3) begin errors++; $display("FAIL timeout snd count: got %0d expected 3", obs_cmd.size()); end
    if (err !== 1'b1) begin errors++; $display("FAIL timeout err: got %b expected 1", err); end
    if (err_code !== ERR_TIMEOUT) begin errors++; $display("FAIL timeout err_code: got %0d expected 2", err_code); end
    if (cmds_done !== '0) begin errors++; $display("FAIL timeout cmds_done: got %0d expected 0", cmds_done); end
    t0 = (obs_cyc.size() > 0) ? obs_cyc[0] : 0;
    for (int i = 0; i < 3; i++) begin
      want = exp_q[0];
      got = (obs_cmd.size() > 0) ? obs_cmd.pop_front() : 16'hxxxx;
      checks += 2;
      if (got !== want) begin errors++; $display("FAIL timeout cmd%0d: got %h expected %h", i, got, want); end
      if (obs_cyc.size() == 0 || obs_cyc[0] != t0 + 51 * i) begin
        errors++;
        $display("FAIL timeout snd%0d cycle: got %0d expected %0d", i, (obs_cyc.size() > 0) ? obs_cyc[0] : -1, t0 + 51 * i);
      end
      if (obs_cyc.size() > 0) void'(obs_cyc.pop_front());
    end
    $display("[%0d] timeout after retries err_code=%0d", cyc, err_code);
    // Kept head succeeds on its second attempt, then a fresh command completes normally.
    clear_obs();
    load(16'h5D22);
    plan.push_back(-1);
    plan.push_back(32'hA5);
    plan.push_back(32'hA5);
    pulse_start();
    wait_idle(1000, ok);
    checks += 5;
    if (!ok) begin errors++; $display("FAIL retry run: still busy after budget, expected idle"); end
    if (obs_cmd.size() != 3) begin errors++; $display("FAIL retry snd count: got %0d expected 3", obs_cmd.size()); end
    if (cmds_done !== CW'(2)) begin errors++; $display("FAIL retry cmds_done: got %0d expected 2", cmds_done); end
    if (err_code !== ERR_NONE) begin errors++; $display("FAIL retry err_code: got %0d expected 0", err_code); end
    if (done_cnt != 1) begin errors++; $display("FAIL retry done pulses: got %0d expected 1", done_cnt); end
    checks++;
    if (obs_cyc.size() < 2 || obs_cyc[1] != obs_cyc[0] + 51) begin
      errors++;
      $display("FAIL retry spacing: got %0d expected 51", (obs_cyc.size() >= 2) ? obs_cyc[1] - obs_cyc[0] : -1);
    end
    want = exp_q[0];
    got = (obs_cmd.size() > 0) ? obs_cmd.pop_front() : 16'hxxxx;
    checks++;
    if (got !== want) begin errors++; $display("FAIL retry cmd0: got %h expected %h", got, want); end
    for (int i = 1; i < 3; i++) begin
      want = exp_q.pop_front();
      got = (obs_cmd.size() > 0) ? obs_cmd.pop_front() : 16'hxxxx;
      checks++;
      if (got !== want) begin errors++; $display("FAIL retry cmd%0d: got %h expected %h", i, got, want); end
    end
    model_cnt -= 2;
    $display("[%0d] retry run complete cmds_done=%0d", cyc, cmds_done);
  endtask

  task automatic test_fifo_full_wrap();
    bit ok;
    logic [15:0] got, want;
    for (int pass = 0; pass < 2; pass++) begin
      clear_obs();
      for (int i = 0; i < 5; i++) begin
        load(16'h4000 + 16'(pass * 16'h0800) + 16'(i * 16'h0111));
        if (i == 3) begin
          checks++;
          if (ld_rdy !== 1'b0) begin errors++; $display("FAIL full ld_rdy after 4th push: got %b expected 0", ld_rdy); end
        end
      end
      pulse_start();
      wait_idle(1000, ok);
      checks += 3;
      if (!ok) begin errors++; $display("FAIL wrap run%0d: still busy after budget, expected idle", pass); end
      if (obs_cmd.size() != 4) begin errors++; $display("FAIL wrap run%0d snd count: got %0d expected 4", pass, obs_cmd.size()); end
      if (cmds_done !== CW'(4)) begin errors++; $display("FAIL wrap run%0d cmds_done: got %0d expected 4", pass, cmds_done); end
      for (int i = 0; i < 4; i++) begin
        want = exp_q.pop_front();
        got = (obs_cmd.size() > 0) ? obs_cmd.pop_front() : 16'hxxxx;
        checks++;
        if (got !== want) begin errors++; $display("FAIL wrap run%0d cmd%0d: got %h expected %h", pass, i, got, want); end
      end
      model_cnt -= 4;
      $display("[%0d] wrap run %0d complete", cyc, pass);
    end
  endtask

  task automatic test_abort_empty();
    bit ok;
    clear_obs();
    load(16'h4A01);
    load(16'h4A02);
    stub_en = 1'b0;
    pulse_start();
    tick(1);
    cmd_snt = 1'b1;
    tick(1);
    cmd_snt = 1'b0;
    tick(1);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL abort pre busy: got %b expected 1", busy); end
    abort = 1'b1;
    resp_rdy = 1'b1;
    resp = 8'hA5;
    tick(1);
    abort = 1'b0;
    resp_rdy = 1'b0;
    exp_q.delete();
    model_cnt = 0;
    tick(1);
    checks += 4;
    if (err !== 1'b1) begin errors++; $display("FAIL abort err: got %b expected 1", err); end
    if (err_code !== ERR_ABORT) begin errors++; $display("FAIL abort err_code: got %0d expected 3", err_code); end
    if (cmds_done !== '0) begin errors++; $display("FAIL abort cmds_done: got %0d expected 0", cmds_done); end
    if (busy !== 1'b0) begin errors++; $display("FAIL abort busy: got %b expected 0", busy); end
    stub_en = 1'b1;
    $display("[%0d] abort err_code=%0d", cyc, err_code);
    // Start on the flushed FIFO goes straight to done.
    clear_obs();
    pulse_start();
    wait_idle(20, ok);
    checks += 6;
    if (!ok) begin errors++; $display("FAIL empty start: still busy after budget, expected idle"); end
    if (done_cnt != 1) begin errors++; $display("FAIL empty start done pulses: got %0d expected 1", done_cnt); end
    if (done_cyc != start_cyc + 2) begin errors++; $display("FAIL empty start done cycle: got %0d expected %0d", done_cyc, start_cyc + 2); end
    if (cmds_done !== '0) begin errors++; $display("FAIL empty start cmds_done: got %0d expected 0", cmds_done); end
    if (obs_cmd.size() != 0) begin errors++; $display("FAIL empty start snd count: got %0d expected 0", obs_cmd.size()); end
    if (err !== 1'b0) begin errors++; $display("FAIL empty start err: got %b expected 0", err); end
    $display("[%0d] empty start done", cyc);
  endtask

  task automatic test_async_reset();
    clear_obs();
    load(16'h4E33);
    plan.push_back(-1);
    pulse_start();
    tick(1);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL prereset busy: got %b expected 1", busy); end
    #2;
    rst_n = 1'b0;
    #1;
    checks += 8;
    if (cmd !== 16'h0)     begin errors++; $display("FAIL async reset cmd: got %h expected 0", cmd); end
    if (snd_cmd !== 1'b0)  begin errors++; $display("FAIL async reset snd_cmd: got %b expected 0", snd_cmd); end
    if (busy !== 1'b0)     begin errors++; $display("FAIL async reset busy: got %b expected 0", busy); end
    if (done !== 1'b0)     begin errors++; $display("FAIL async reset done: got %b expected 0", done); end
    if (err !== 1'b0)      begin errors++; $display("FAIL async reset err: got %b expected 0", err); end
    if (err_code !== 2'd0) begin errors++; $display("FAIL async reset err_code: got %0d expected 0", err_code); end
    if (cmds_done !== '0)  begin errors++; $display("FAIL async reset cmds_done: got %0d expected 0", cmds_done); end
    if (ld_rdy !== 1'b1)   begin errors++; $display("FAIL async reset ld_rdy: got %b expected 1", ld_rdy); end
    exp_q.delete();
    model_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    tick(10);
    checks += 2;
    if (busy !== 1'b0) begin errors++; $display("FAIL post reset busy: got %b expected 0", busy); end
    if (obs_cmd.size() != 1) begin errors++; $display("FAIL post reset strobes: got %0d expected 1", obs_cmd.size()); end
    $display("[%0d] async reset mid WAIT_SNT checked", cyc);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic_ack();
    test_nack();
    test_timeout();
    test_fifo_full_wrap();
    test_abort_empty();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
